// File: rtl/tx_intf_pkg.sv
// Shared definitions for the PS->PL TX DMA stream receiver: FSM states and
// header1 bit-field offsets.
package tx_intf_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HDR1       = 3'd1,
        WAIT_GRANT = 3'd2,
        STREAM     = 3'd3,
        DRAIN      = 3'd4,
        DONE_WAIT  = 3'd5
    } tx_state_t;

    localparam int HDR1_LEN_LSB  = 32;
    localparam int HDR1_RATE_LSB = 48;
    localparam int HDR1_HT_BIT   = 52;

    // Rate byte as seen by the TX core: {ht_flag, 3'b0, rate}
    function automatic logic [7:0] build_rate(input logic ht, input logic [3:0] rate);
        return {ht, 3'b000, rate};
    endfunction

endpackage

// File: rtl/tx_intf_intr_delay.sv
// Turns a tx_done event into a single interrupt pulse delay_top+1 cycles later;
// a new event restarts the count.
module tx_intf_intr_delay (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [14:0] delay_top,
    output logic        intr
);

    logic [14:0] cnt;
    logic        active;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
            intr   <= 1'b0;
        end else begin
            intr <= 1'b0;
            if (start) begin
                cnt    <= '0;
                active <= 1'b1;
            end else if (active) begin
                // Count stops one past the limit so the pulse fires only once
                if (cnt == delay_top) begin
                    intr   <= 1'b1;
                    active <= 1'b0;
                end
                cnt <= cnt + 15'd1;
            end
        end
    end

endmodule

// File: rtl/tx_intf_s_axis_to_pl.sv
// Receive side of the PS->PL TX DMA stream: parses the 2-word header, requests a
// TX slot, forwards payload to the TX core and polices tlast against the length.
module tx_intf_s_axis_to_pl
    import tx_intf_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int TSF_TIMER_WIDTH        = 64,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic                              tx_start_req,
    input  logic                              tx_start_grant,
    output logic [TSF_TIMER_WIDTH-1:0]        tsf_start_val,
    output logic [7:0]                        pkt_rate,
    output logic [15:0]                       pkt_len,
    output logic                              hdr_valid,
    output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] num_dma_symbol,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0] data_out,
    output logic                              data_out_valid,
    input  logic                              data_out_ready,
    input  logic                              tx_done,
    output logic                              tlast_err,
    output logic                              timeout_err,
    input  logic                              timeout_enable,
    input  logic [12:0]                       timeout_top,
    input  logic                              tsf_pulse_1M,
    input  logic [14:0]                       intr_delay_top,
    output logic                              tx_pkt_intr
);

    localparam int NW = MAX_BIT_NUM_DMA_SYMBOL;

    tx_state_t     state, state_nxt;
    logic [NW-1:0] word_cnt;
    logic [12:0]   timer;
    logic          tlast_seen;
    logic          tlast_err_nxt, timeout_nxt;
    logic          hs, last_word, timing, timeout_hit;
    logic [15:0]   hdr_len;
    logic [NW-1:0] hdr_num;

    assign hdr_len = s_axis_tdata[HDR1_LEN_LSB +: 16];
    assign hdr_num = NW'(hdr_len[15:3]) + NW'(hdr_len[2:0] != 3'd0);

    // Payload path is combinational so the core sees DMA words with zero latency
    assign s_axis_tready = !rst && ((state == IDLE) || (state == HDR1) || (state == DRAIN) ||
                                    ((state == STREAM) && data_out_ready));
    assign hs             = s_axis_tvalid && s_axis_tready;
    assign data_out_valid = (state == STREAM) && s_axis_tvalid;
    assign data_out       = (state == STREAM) ? s_axis_tdata : '0;
    assign tx_start_req   = (state == WAIT_GRANT);

    assign last_word   = (word_cnt == num_dma_symbol - NW'(1));
    assign timing      = (state == WAIT_GRANT) || (state == STREAM) || (state == DONE_WAIT);
    assign timeout_hit = timing && timeout_enable && (timer > timeout_top);

    always_comb begin
        state_nxt     = state;
        tlast_err_nxt = 1'b0;
        timeout_nxt   = 1'b0;
        case (state)
            IDLE: if (hs) begin
                if (s_axis_tlast) tlast_err_nxt = 1'b1;
                else              state_nxt     = HDR1;
            end
            HDR1: if (hs) begin
                if (s_axis_tlast) begin
                    if (hdr_num == '0) state_nxt = WAIT_GRANT;
                    else begin
                        tlast_err_nxt = 1'b1;
                        state_nxt     = IDLE;
                    end
                end else if (hdr_num == '0) begin
                    tlast_err_nxt = 1'b1;
                    state_nxt     = DRAIN;
                end else begin
                    state_nxt = WAIT_GRANT;
                end
            end
            WAIT_GRANT: begin
                if (tx_start_grant) state_nxt = (num_dma_symbol == '0) ? DONE_WAIT : STREAM;
                else if (timeout_hit) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = tlast_seen ? IDLE : DRAIN;
                end
            end
            STREAM: begin
                tlast_err_nxt = hs && (s_axis_tlast != last_word);
                if (timeout_hit) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = (hs && s_axis_tlast) ? IDLE : DRAIN;
                end else if (hs && s_axis_tlast) state_nxt = DONE_WAIT;
                else if (hs && last_word)        state_nxt = DRAIN;
            end
            DRAIN: if (hs && s_axis_tlast) state_nxt = IDLE;
            DONE_WAIT: begin
                if (tx_done) state_nxt = IDLE;
                else if (timeout_hit) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            word_cnt       <= '0;
            timer          <= '0;
            tlast_seen     <= 1'b0;
            tsf_start_val  <= '0;
            pkt_rate       <= '0;
            pkt_len        <= '0;
            num_dma_symbol <= '0;
            hdr_valid      <= 1'b0;
            tlast_err      <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            tlast_err   <= tlast_err_nxt;
            timeout_err <= timeout_nxt;
            hdr_valid   <= (state == HDR1) && hs;
            if (state == IDLE) begin
                tlast_seen <= 1'b0;
                if (hs && !s_axis_tlast) tsf_start_val <= s_axis_tdata[TSF_TIMER_WIDTH-1:0];
            end
            if ((state == HDR1) && hs) begin
                pkt_len        <= hdr_len;
                pkt_rate       <= build_rate(s_axis_tdata[HDR1_HT_BIT], s_axis_tdata[HDR1_RATE_LSB +: 4]);
                num_dma_symbol <= hdr_num;
                tlast_seen     <= s_axis_tlast;
            end
            if (state != STREAM) word_cnt <= '0;
            else if (hs)         word_cnt <= word_cnt + NW'(1);
            // Timer restarts on any state change and holds at all-ones
            if (state_nxt != state) timer <= '0;
            else if (timing && tsf_pulse_1M && (timer != '1)) timer <= timer + 13'd1;
        end
    end

    tx_intf_intr_delay u_intr_delay (
        .clk       (clk),
        .rst       (rst),
        .start     ((state == DONE_WAIT) && tx_done),
        .delay_top (intr_delay_top),
        .intr      (tx_pkt_intr)
    );

endmodule
